// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding and baud counter sizing.
// uart_tx imports the same package.
package uart_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } uart_state_e;

    function automatic int baud_cnt_max(input int clk_freq, input int uart_bps);
        return clk_freq / uart_bps;
    endfunction

    // Enough bits to count 0..max_cnt-1; never narrower than one bit.
    function automatic int baud_cnt_width(input int max_cnt);
        return (max_cnt > 2) ? $clog2(max_cnt) : 1;
    endfunction

endpackage

// File: rtl/uart_rx_if.sv
// Receiver-side bundle: serial input line and the byte/strobe outputs.
interface uart_rx_if;
    logic       rx;
    logic [7:0] po_data;
    logic       po_flag;
    logic       po_err;

    modport master (input rx, output po_data, output po_flag, output po_err);
    modport slave  (output rx, input po_data, input po_flag, input po_err);
endinterface

// File: rtl/uart_rx_sync.sv
// Two-flop synchronizer for the asynchronous rx line plus a falling-edge detector.
module uart_rx_sync (
    input  logic clk_i,
    input  logic rst_i,
    input  logic rx_i,
    output logic rx_s_o,
    output logic start_nedge_o
);
    logic sync1_q;
    logic sync2_q;
    logic dly_q;

    // Everything resets high so the idle line never looks like a start edge.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
            dly_q   <= 1'b1;
        end else begin
            sync1_q <= rx_i;
            sync2_q <= sync1_q;
            dly_q   <= sync2_q;
        end
    end

    assign rx_s_o        = sync2_q;
    assign start_nedge_o = dly_q & ~sync2_q;

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver: mid-bit sampling, LSB first, one-cycle po_flag/po_err strobes.
module uart_rx
    import uart_pkg::*;
#(
    parameter int UART_BPS = 9600,
    parameter int CLK_FREQ = 50_000_000
) (
    input logic       sys_clk,
    input logic       sys_rst,
    uart_rx_if.master bus
);
    localparam int BAUD_CNT_MAX = baud_cnt_max(CLK_FREQ, UART_BPS);
    localparam int CNT_W        = baud_cnt_width(BAUD_CNT_MAX);
    localparam logic [CNT_W-1:0] BAUD_LAST = CNT_W'(BAUD_CNT_MAX - 1);
    localparam logic [CNT_W-1:0] SAMPLE_PT = CNT_W'(BAUD_CNT_MAX / 2 - 1);

    logic             rx_s;
    logic             start_nedge;
    uart_state_e      state_q;
    logic [CNT_W-1:0] baud_cnt_q;
    logic [CNT_W-1:0] baud_cnt_d;
    logic [3:0]       bit_cnt_q;
    logic [7:0]       shreg_q;
    logic [7:0]       po_data_q;
    logic             po_flag_q;
    logic             po_err_q;
    logic             sample;

    uart_rx_sync u_sync (
        .clk_i         (sys_clk),
        .rst_i         (sys_rst),
        .rx_i          (bus.rx),
        .rx_s_o        (rx_s),
        .start_nedge_o (start_nedge)
    );

    // The bit-period counter only runs while a frame is in progress.
    always_comb begin
        baud_cnt_d = '0;
        if (state_q != IDLE && baud_cnt_q != BAUD_LAST) begin
            baud_cnt_d = baud_cnt_q + CNT_W'(1);
        end
    end

    assign sample = (state_q != IDLE) && (baud_cnt_q == SAMPLE_PT);

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state_q    <= IDLE;
            baud_cnt_q <= '0;
            bit_cnt_q  <= 4'd0;
            shreg_q    <= 8'd0;
            po_data_q  <= 8'd0;
            po_flag_q  <= 1'b0;
            po_err_q   <= 1'b0;
        end else begin
            po_flag_q  <= 1'b0;
            po_err_q   <= 1'b0;
            baud_cnt_q <= baud_cnt_d;
            unique case (state_q)
                IDLE: begin
                    if (start_nedge) begin
                        state_q    <= START;
                        baud_cnt_q <= '0;
                    end
                end
                START: begin
                    // A start bit that is high again at mid-bit was only a glitch.
                    if (sample) begin
                        bit_cnt_q <= 4'd0;
                        state_q   <= rx_s ? IDLE : DATA;
                    end
                end
                DATA: begin
                    if (sample) begin
                        shreg_q   <= {rx_s, shreg_q[7:1]};
                        bit_cnt_q <= bit_cnt_q + 4'd1;
                        if (bit_cnt_q == 4'd7) begin
                            state_q <= STOP;
                        end
                    end
                end
                STOP: begin
                    // Leaving at mid-stop leaves half a bit to catch a back-to-back start edge.
                    if (sample) begin
                        if (rx_s) begin
                            po_data_q <= shreg_q;
                            po_flag_q <= 1'b1;
                        end else begin
                            po_err_q  <= 1'b1;
                        end
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.po_data = po_data_q;
    assign bus.po_flag = po_flag_q;
    assign bus.po_err  = po_err_q;

endmodule

// File: tb/tb_uart_rx.sv
// Randomized self-checking bench for uart_rx against a frame-level event model.
module tb_uart_rx;
    import uart_pkg::*;

    localparam int CLK_FREQ = 1_600_000;
    localparam int UART_BPS = 100_000;
    localparam int BIT      = CLK_FREQ / UART_BPS;
    localparam int HALF     = BIT / 2;
    // Clocks from driving the start edge to seeing the strobe: 9.5 bits plus sync/edge delay.
    localparam int LAT      = 9 * BIT + HALF + 3;

    typedef struct {
        bit          isErr;
        logic [7:0]  data;
        int unsigned cycle;
    } evT;

    logic        sysClk;
    logic        sysRst;
    int unsigned cycleCount;
    int          checkCount;
    int          errorCount;
    logic [7:0]  lastGood;
    logic        prevStrobe;
    evT          obsQ[$];
    evT          expQ[$];

    uart_rx_if bus ();

    uart_rx #(
        .UART_BPS (UART_BPS),
        .CLK_FREQ (CLK_FREQ)
    ) dut (
        .sys_clk (sysClk),
        .sys_rst (sysRst),
        .bus     (bus)
    );

    initial sysClk = 1'b0;
    always #10 sysClk = ~sysClk;

    initial cycleCount = 0;
    always @(posedge sysClk) cycleCount <= cycleCount + 1;

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checkCount++;
        if (actual !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
        end
    endtask

    // Every strobe is recorded as an event together with the cycle it was seen.
    initial prevStrobe = 1'b0;
    always @(negedge sysClk) begin
        if (sysRst) begin
            prevStrobe <= 1'b0;
        end else begin
            if (bus.po_flag || bus.po_err) begin
                checkOutput("flagErrExclusive", 32'(bus.po_flag & bus.po_err), 32'd0);
                checkOutput("strobeWidth", 32'(prevStrobe), 32'd0);
                obsQ.push_back('{bus.po_err, bus.po_data, cycleCount});
            end
            prevStrobe <= bus.po_flag | bus.po_err;
        end
    end

    task automatic waitCycles(input int n);
        repeat (n) @(negedge sysClk);
    endtask

    // Drives one 8N1 frame and records what the receiver must report for it.
    task automatic applyStimulus(input logic [7:0] data, input bit stopOk);
        evT e;
        e.cycle = cycleCount;
        bus.rx = 1'b0;
        waitCycles(BIT);
        for (int i = 0; i < 8; i++) begin
            bus.rx = data[i];
            waitCycles(BIT);
        end
        bus.rx = stopOk;
        waitCycles(BIT);
        if (!stopOk) begin
            bus.rx = 1'b1;
            waitCycles(BIT);
        end
        e.isErr = !stopOk;
        if (stopOk) lastGood = data;
        e.data = lastGood;
        expQ.push_back(e);
    endtask

    task automatic compareEvents(input string phase);
        int n;
        checkOutput({phase, ".eventCount"}, 32'(obsQ.size()), 32'(expQ.size()));
        n = (obsQ.size() < expQ.size()) ? obsQ.size() : expQ.size();
        for (int i = 0; i < n; i++) begin
            checkOutput({phase, ".kind"}, 32'(obsQ[i].isErr), 32'(expQ[i].isErr));
            checkOutput({phase, ".data"}, 32'(obsQ[i].data), 32'(expQ[i].data));
            checkOutput({phase, ".latency"}, obsQ[i].cycle - expQ[i].cycle, 32'(LAT));
        end
        checkOutput({phase, ".poDataHeld"}, 32'(bus.po_data), 32'(lastGood));
        obsQ.delete();
        expQ.delete();
    endtask

    initial begin
        evT brk;
        checkCount = 0;
        errorCount = 0;
        lastGood   = 8'h00;
        sysRst     = 1'b1;
        bus.rx     = 1'b1;
        waitCycles(3);
        sysRst = 1'b0;
        checkOutput("reset.poData", 32'(bus.po_data), 32'h0);
        checkOutput("reset.poFlag", 32'(bus.po_flag), 32'h0);
        checkOutput("reset.poErr", 32'(bus.po_err), 32'h0);
        waitCycles(2 * BIT);

        $display("[TB] single frame 0x55");
        applyStimulus(8'h55, 1'b1);
        waitCycles(2 * BIT);
        compareEvents("frame55");

        $display("[TB] back-to-back bytes 0..7");
        for (int i = 0; i < 8; i++) applyStimulus(8'(i), 1'b1);
        waitCycles(2 * BIT);
        compareEvents("burst");

        $display("[TB] short start glitch");
        bus.rx = 1'b0;
        waitCycles(BIT / 4);
        bus.rx = 1'b1;
        waitCycles(3 * BIT);
        compareEvents("glitch");

        $display("[TB] bad stop bit on 0xA5");
        applyStimulus(8'hA5, 1'b0);
        waitCycles(2 * BIT);
        compareEvents("framing");

        $display("[TB] reset during data bit 3");
        bus.rx = 1'b0;
        waitCycles(BIT);
        bus.rx = 1'b0;
        waitCycles(BIT);
        bus.rx = 1'b1;
        waitCycles(BIT);
        bus.rx = 1'b0;
        waitCycles(BIT);
        bus.rx = 1'b1;
        waitCycles(HALF);
        sysRst = 1'b1;
        waitCycles(2);
        sysRst = 1'b0;
        lastGood = 8'h00;
        checkOutput("midReset.poData", 32'(bus.po_data), 32'h0);
        checkOutput("midReset.poFlag", 32'(bus.po_flag), 32'h0);
        checkOutput("midReset.poErr", 32'(bus.po_err), 32'h0);
        waitCycles(2 * BIT);
        applyStimulus(8'h3C, 1'b1);
        waitCycles(2 * BIT);
        compareEvents("afterReset");

        $display("[TB] line break then 0x81");
        brk.cycle = cycleCount;
        brk.isErr = 1'b1;
        brk.data  = lastGood;
        bus.rx = 1'b0;
        waitCycles(20 * BIT);
        expQ.push_back(brk);
        bus.rx = 1'b1;
        waitCycles(2 * BIT);
        applyStimulus(8'h81, 1'b1);
        waitCycles(2 * BIT);
        compareEvents("break");

        $display("[TB] random frames");
        for (int i = 0; i < 12; i++) begin
            applyStimulus(8'($urandom_range(0, 255)), $urandom_range(0, 3) != 0);
            waitCycles($urandom_range(0, 2 * BIT));
        end
        waitCycles(2 * BIT);
        compareEvents("random");

        $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
        $finish;
    end

endmodule
